channel_sequencer: RTL

//  Responder side of the conv-layer top controller handshake. Consumes one-cycle command strobes (c_load, cin, cout).

---
 rtl/channel_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/channel_sequencer.sv
// Responder side of the conv-layer controller handshake: tracks input/output channel
// progress and publishes per-channel base addresses for the weight, feature-map and output memories.
module channel_sequencer #(
  parameter  int N_IN     = 4,
  parameter  int N_OUT    = 8,
  parameter  int K        = 3,
  parameter  int IN_AREA  = 196,
  parameter  int OUT_AREA = 144,
  parameter  int AW       = 16,
  localparam int CIW      = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int COW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           c_load,
  input  logic           cin,
  input  logic           cout,
  output logic           cin_done,
  output logic           cout_done,
  output logic           is_single_input_channel,
  output logic [CIW-1:0] cin_idx,
  output logic [COW-1:0] cout_idx,
  output logic [AW-1:0]  weight_base,
  output logic [AW-1:0]  fmap_base,
  output logic [AW-1:0]  out_base,
  output logic [COW-1:0] bias_addr,
  output logic           acc_clear,
  output logic           out_commit,
  output logic           layer_done,
  output logic           seq_err
);

  localparam int             CCW       = $clog2(N_IN + 1);
  localparam int             KK        = K * K;
  localparam logic [AW-1:0]  IN_STEP   = AW'(IN_AREA);
  localparam logic [AW-1:0]  KK_STEP   = AW'(KK);
  localparam logic [AW-1:0]  OUT_STEP  = AW'(OUT_AREA);
  localparam logic [CCW-1:0] CIN_FULL  = CCW'(N_IN);
  localparam logic [COW-1:0] COUT_LAST = COW'(N_OUT - 1);
  localparam logic           SINGLE_IN = (N_IN == 1);

  typedef enum logic [2:0] {
    CMD_IDLE   = 3'd0,
    CMD_LOAD   = 3'd1,
    CMD_SELECT = 3'd2,
    CMD_COUT   = 3'd3,
    CMD_REJECT = 3'd4
  } cmd_e;

  logic [CCW-1:0] cin_cnt_r,     cin_cnt_nxt_s;
  logic [AW-1:0]  f_ptr_r,       f_ptr_nxt_s;
  logic [AW-1:0]  w_ptr_r,       w_ptr_nxt_s;
  logic [CIW-1:0] cin_idx_r,     cin_idx_nxt_s;
  logic [COW-1:0] cout_idx_r,    cout_idx_nxt_s;
  logic [AW-1:0]  weight_base_r, weight_base_nxt_s;
  logic [AW-1:0]  fmap_base_r,   fmap_base_nxt_s;
  logic [AW-1:0]  out_base_r,    out_base_nxt_s;
  logic           acc_clear_r,   acc_clear_nxt_s;
  logic           out_commit_r,  out_commit_nxt_s;
  logic           layer_done_r,  layer_done_nxt_s;
  logic           seq_err_r,     seq_err_nxt_s;

  cmd_e           cmd_s;
  logic           viol_s;
  logic           any_s;
  logic           multi_s;
  logic           cin_done_s;
  logic           cout_done_s;
  logic           sel_s;
  logic [CCW-1:0] sel_cnt_s;
  logic [AW-1:0]  sel_fptr_s;

  assign cin_done_s  = (cin_cnt_r == CIN_FULL);
  assign cout_done_s = (cout_idx_r == COUT_LAST);
  assign any_s       = c_load | cin | cout;
  assign multi_s     = (c_load & cin) | (c_load & cout) | (cin & cout);

  // Strobe arbitration: c_load > cin > cout, everything refused once the layer is finished
  always_comb begin
    cmd_s  = CMD_IDLE;
    viol_s = 1'b0;
    if (layer_done_r) begin
      if (any_s) begin
        cmd_s  = CMD_REJECT;
        viol_s = 1'b1;
      end else begin
        cmd_s  = CMD_IDLE;
        viol_s = 1'b0;
      end
    end else if (c_load) begin
      cmd_s  = CMD_LOAD;
      viol_s = multi_s;
    end else if (cin) begin
      if (cin_done_s) begin
        cmd_s  = CMD_REJECT;
        viol_s = 1'b1;
      end else begin
        cmd_s  = CMD_SELECT;
        viol_s = multi_s;
      end
    end else if (cout) begin
      cmd_s  = CMD_COUT;
      viol_s = ~cin_done_s;
    end else begin
      cmd_s  = CMD_IDLE;
      viol_s = 1'b0;
    end
  end

  // A single-input layer selects channel 0 on the same edge as c_load, starting from cleared pointers
  always_comb begin
    sel_s      = 1'b0;
    sel_cnt_s  = cin_cnt_r;
    sel_fptr_s = f_ptr_r;
    if (cmd_s == CMD_LOAD) begin
      sel_s      = SINGLE_IN;
      sel_cnt_s  = {CCW{1'b0}};
      sel_fptr_s = {AW{1'b0}};
    end else begin
      sel_s      = (cmd_s == CMD_SELECT);
      sel_cnt_s  = cin_cnt_r;
      sel_fptr_s = f_ptr_r;
    end
  end

  // Next-state computation for counters, bases and flags
  always_comb begin
    cin_cnt_nxt_s     = cin_cnt_r;
    f_ptr_nxt_s       = f_ptr_r;
    w_ptr_nxt_s       = w_ptr_r;
    cin_idx_nxt_s     = cin_idx_r;
    cout_idx_nxt_s    = cout_idx_r;
    weight_base_nxt_s = weight_base_r;
    fmap_base_nxt_s   = fmap_base_r;
    out_base_nxt_s    = out_base_r;
    acc_clear_nxt_s   = 1'b0;
    out_commit_nxt_s  = 1'b0;
    layer_done_nxt_s  = layer_done_r;
    seq_err_nxt_s     = seq_err_r | viol_s;

    case (cmd_s)
      CMD_LOAD: begin
        cin_cnt_nxt_s   = {CCW{1'b0}};
        f_ptr_nxt_s     = {AW{1'b0}};
        acc_clear_nxt_s = 1'b1;
      end
      CMD_COUT: begin
        out_commit_nxt_s = 1'b1;
        if (cout_done_s) begin
          layer_done_nxt_s = 1'b1;
        end else begin
          cout_idx_nxt_s = cout_idx_r + COW'(1);
          out_base_nxt_s = out_base_r + OUT_STEP;
        end
      end
      default: begin
        acc_clear_nxt_s  = 1'b0;
        out_commit_nxt_s = 1'b0;
      end
    endcase

    // w_ptr only ever advances, so weight_base walks the cout-major, cin-minor layout without a multiplier
    if (sel_s) begin
      cin_idx_nxt_s     = sel_cnt_s[CIW-1:0];
      fmap_base_nxt_s   = sel_fptr_s;
      weight_base_nxt_s = w_ptr_r;
      cin_cnt_nxt_s     = sel_cnt_s + CCW'(1);
      f_ptr_nxt_s       = sel_fptr_s + IN_STEP;
      w_ptr_nxt_s       = w_ptr_r + KK_STEP;
    end else begin
      w_ptr_nxt_s = w_ptr_r;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_cnt_r     <= {CCW{1'b0}};
      f_ptr_r       <= {AW{1'b0}};
      w_ptr_r       <= {AW{1'b0}};
      cin_idx_r     <= {CIW{1'b0}};
      cout_idx_r    <= {COW{1'b0}};
      weight_base_r <= {AW{1'b0}};
      fmap_base_r   <= {AW{1'b0}};
      out_base_r    <= {AW{1'b0}};
      acc_clear_r   <= 1'b0;
      out_commit_r  <= 1'b0;
      layer_done_r  <= 1'b0;
      seq_err_r     <= 1'b0;
    end else begin
      cin_cnt_r     <= cin_cnt_nxt_s;
      f_ptr_r       <= f_ptr_nxt_s;
      w_ptr_r       <= w_ptr_nxt_s;
      cin_idx_r     <= cin_idx_nxt_s;
      cout_idx_r    <= cout_idx_nxt_s;
      weight_base_r <= weight_base_nxt_s;
      fmap_base_r   <= fmap_base_nxt_s;
      out_base_r    <= out_base_nxt_s;
      acc_clear_r   <= acc_clear_nxt_s;
      out_commit_r  <= out_commit_nxt_s;
      layer_done_r  <= layer_done_nxt_s;
      seq_err_r     <= seq_err_nxt_s;
    end
  end

  assign cin_done                = cin_done_s;
  assign cout_done               = cout_done_s;
  assign is_single_input_channel = SINGLE_IN;
  assign cin_idx                 = cin_idx_r;
  assign cout_idx                = cout_idx_r;
  assign weight_base             = weight_base_r;
  assign fmap_base               = fmap_base_r;
  assign out_base                = out_base_r;
  assign bias_addr               = cout_idx_r;
  assign acc_clear               = acc_clear_r;
  assign out_commit              = out_commit_r;
  assign layer_done              = layer_done_r;
  assign seq_err                 = seq_err_r;

endmodule
